// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared op/state encodings and default width for the logic-op arbiter
package logic_unit_pkg;
  localparam int LU_WIDTH = 64;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_XNOR} logic_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
endpackage

// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: two-requester request/response bundle for the logic-op arbiter
interface logic_unit_arbiter_if import logic_unit_pkg::*; #(parameter int WIDTH = LU_WIDTH);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic_op_e req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic_op_e req_op1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic rsp_zero;
  logic busy;
  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );
  modport slave (
    input req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/logic_unit_64.sv
// logic_unit_64: combinational AND/OR/XOR/XNOR gate arrays with a 4:1 result mux
module logic_unit_64 import logic_unit_pkg::*; #(
  parameter int WIDTH = LU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic_op_e        op,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] y_and, y_or, y_xor, y_xnor;
  assign y_and  = a & b;
  assign y_or   = a | b;
  assign y_xor  = a ^ b;
  assign y_xnor = ~(a ^ b);
  always_comb y = op == OP_AND ? y_and : op == OP_OR ? y_or : op == OP_XOR ? y_xor : y_xnor;
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sequencer sharing one logic unit between two requesters
module logic_unit_arbiter import logic_unit_pkg::*; #(
  parameter int WIDTH = LU_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic reset_n,
  logic_unit_arbiter_if.slave bus
);
  arb_state_e state;
  logic last_grant, owner, gnt, rsp_zero_q, busy_q;
  logic [3:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, y, res_q;
  logic_op_e op_q;
  logic [1:0] rsp_valid_q;
  always_comb gnt = &bus.req_valid ? ~last_grant : bus.req_valid[1];
  assign bus.req_ready  = (state == IDLE && reset_n && |bus.req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = busy_q;
  logic_unit_64 #(.WIDTH(WIDTH)) u_lu (.a(a_q), .b(b_q), .op(op_q), .y(y));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      res_q       <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          a_q        <= gnt ? bus.req_a1 : bus.req_a0;
          b_q        <= gnt ? bus.req_b1 : bus.req_b0;
          op_q       <= gnt ? bus.req_op1 : bus.req_op0;
          owner      <= gnt;
          last_grant <= gnt;
          cnt        <= 4'(SETTLE_CYCLES - 1);
          busy_q     <= 1'b1;
          state      <= EXEC;
        end
        EXEC: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          res_q       <= y;
          rsp_zero_q  <= ~|y;
          rsp_valid_q <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: if (bus.rsp_ready[owner]) begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: randomized and directed checks against a truth-table reference model
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  logic model_last;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic_unit_arbiter_if #(.WIDTH(W)) bus1 ();
  logic_unit_arbiter_if #(.WIDTH(W)) bus4 ();
  logic_unit_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  logic_unit_arbiter #(.WIDTH(W), .SETTLE_CYCLES(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    logic [3:0] tt;
    logic [W-1:0] r;
    tt = op == 2'd0 ? 4'b1000 : op == 2'd1 ? 4'b1110 : op == 2'd2 ? 4'b0110 : 4'b1001;
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic init_bus();
    bus1.req_valid = 0; bus1.rsp_ready = 0;
    bus1.req_a0 = 0; bus1.req_b0 = 0; bus1.req_op0 = OP_AND;
    bus1.req_a1 = 0; bus1.req_b1 = 0; bus1.req_op1 = OP_AND;
    bus4.req_valid = 0; bus4.rsp_ready = 0;
    bus4.req_a0 = 0; bus4.req_b0 = 0; bus4.req_op0 = OP_AND;
    bus4.req_a1 = 0; bus4.req_b1 = 0; bus4.req_op1 = OP_AND;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic txn(input logic [1:0] v,
                     input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] o0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] o1,
                     input int hold,
                     output logic [1:0] rdy, output logic [1:0] vobs, output int lat,
                     output logic [W-1:0] res, output logic z,
                     output logic held_ok, output logic idle_ok, output int acc);
    bus1.req_valid = v;
    bus1.req_a0 = a0; bus1.req_b0 = b0; bus1.req_op0 = logic_op_e'(o0);
    bus1.req_a1 = a1; bus1.req_b1 = b1; bus1.req_op1 = logic_op_e'(o1);
    acc = cyc;
    #1 rdy = bus1.req_ready;
    @(posedge clk); @(negedge clk);
    bus1.req_a0 = rnd64(); bus1.req_b0 = rnd64(); bus1.req_op0 = logic_op_e'($urandom_range(0, 3));
    bus1.req_a1 = rnd64(); bus1.req_b1 = rnd64(); bus1.req_op1 = logic_op_e'($urandom_range(0, 3));
    lat = 0;
    while (bus1.rsp_valid == 2'b00 && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    vobs = bus1.rsp_valid; res = bus1.rsp_result; z = bus1.rsp_zero;
    held_ok = 1'b1;
    repeat (hold) begin
      bus1.rsp_ready = ~vobs;
      @(posedge clk); @(negedge clk);
      if (bus1.rsp_valid !== vobs || bus1.req_ready !== 2'b00 || bus1.rsp_result !== res) held_ok = 1'b0;
    end
    bus1.rsp_ready = vobs | (2'($urandom_range(0, 3)) & ~vobs);
    @(posedge clk); @(negedge clk);
    bus1.rsp_ready = 2'b00;
    bus1.req_valid = 2'b00;
    idle_ok = bus1.rsp_valid === 2'b00 && bus1.busy === 1'b0 && bus1.rsp_result === res;
  endtask

  task automatic test_reset();
    init_bus();
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (bus1.rsp_valid !== 2'b00 || bus1.req_ready !== 2'b00 || bus1.busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got valid=%b ready=%b busy=%b exp 00 00 0", bus1.rsp_valid, bus1.req_ready, bus1.busy);
    end
    total++; if (bus1.rsp_result !== '0 || bus1.rsp_zero !== 1'b0 || bus4.rsp_result !== '0) begin
      bad++; $display("FAIL reset_data got res=%h zero=%b res4=%h exp 0", bus1.rsp_result, bus1.rsp_zero, bus4.rsp_result);
    end
    do_reset();
  endtask

  task automatic test_xor();
    logic [1:0] rdy, vobs; int lat, acc; logic [W-1:0] res; logic z, h, i;
    txn(2'b01, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 2'd2, rnd64(), rnd64(), 2'd0, 0,
        rdy, vobs, lat, res, z, h, i, acc);
    model_last = 1'b0;
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL xor_ready got=%b exp=01", rdy); end
    total++; if (lat !== 1 || vobs !== 2'b01) begin bad++; $display("FAIL xor_latency got lat=%0d valid=%b exp 1 01", lat, vobs); end
    total++; if (res !== 64'hF00F_F00F_F00F_F00F || z !== 1'b0) begin
      bad++; $display("FAIL xor_result got=%h z=%b exp=f00ff00ff00ff00f z=0", res, z);
    end
    total++; if (i !== 1'b1) begin bad++; $display("FAIL xor_complete got idle_ok=%b exp=1", i); end
  endtask

  task automatic test_zero();
    logic [1:0] rdy, vobs; int lat, acc; logic [W-1:0] res; logic z, h, i;
    txn(2'b10, rnd64(), rnd64(), 2'd1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'd2, 0,
        rdy, vobs, lat, res, z, h, i, acc);
    model_last = 1'b1;
    total++; if (rdy !== 2'b10 || vobs !== 2'b10) begin bad++; $display("FAIL zero_owner got ready=%b valid=%b exp 10 10", rdy, vobs); end
    total++; if (res !== '0 || z !== 1'b1) begin bad++; $display("FAIL zero_flag got=%h z=%b exp=0 z=1", res, z); end
  endtask

  task automatic test_alternation();
    logic [1:0] rdy, vobs; int lat, acc, prev; logic [W-1:0] res, a0, b0, a1, b1; logic [1:0] o0, o1; logic z, h, i, w;
    do_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      a0 = rnd64(); b0 = rnd64(); a1 = rnd64(); b1 = rnd64();
      o0 = 2'($urandom_range(0, 3)); o1 = 2'($urandom_range(0, 3));
      w = 1'(k % 2);
      txn(2'b11, a0, b0, o0, a1, b1, o1, 0, rdy, vobs, lat, res, z, h, i, acc);
      total++; if (rdy !== (w ? 2'b10 : 2'b01) || vobs !== rdy) begin
        bad++; $display("FAIL alt_grant[%0d] got ready=%b valid=%b exp winner=%0d", k, rdy, vobs, w);
      end
      total++; if (res !== (w ? ref_op(a1, b1, o1) : ref_op(a0, b0, o0))) begin
        bad++; $display("FAIL alt_result[%0d] got=%h exp=%h", k, res, w ? ref_op(a1, b1, o1) : ref_op(a0, b0, o0));
      end
      if (k > 0) begin
        total++; if (acc - prev !== 3) begin bad++; $display("FAIL alt_spacing[%0d] got=%0d exp=3", k, acc - prev); end
      end
      prev = acc;
    end
    model_last = 1'b1;
  endtask

  task automatic test_hold();
    logic [1:0] rdy, vobs; int lat, acc, acc1; logic [W-1:0] res, res1, a1, b1; logic z, h, i;
    a1 = rnd64(); b1 = rnd64();
    txn(2'b10, rnd64(), rnd64(), 2'd0, a1, b1, 2'd1, 10, rdy, vobs, lat, res1, z, h, i, acc1);
    total++; if (h !== 1'b1 || vobs !== 2'b10) begin bad++; $display("FAIL hold_stall got held_ok=%b valid=%b exp 1 10", h, vobs); end
    total++; if (res1 !== (a1 | b1)) begin bad++; $display("FAIL hold_result got=%h exp=%h", res1, a1 | b1); end
    txn(2'b10, rnd64(), rnd64(), 2'd0, a1, b1, 2'd3, 0, rdy, vobs, lat, res, z, h, i, acc);
    total++; if (rdy !== 2'b10 || acc - acc1 !== 13) begin
      bad++; $display("FAIL hold_release got ready=%b spacing=%0d exp 10 13", rdy, acc - acc1);
    end
    model_last = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] rdy, vobs, v, o0, o1, er; int lat, acc; logic [W-1:0] res, a0, b0, a1, b1, e; logic z, h, i, w;
    for (int k = 0; k < 30; k++) begin
      v = 2'($urandom_range(1, 3));
      a0 = rnd64(); b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd64();
      a1 = rnd64(); b1 = ($urandom_range(0, 3) == 0) ? a1 : rnd64();
      o0 = 2'($urandom_range(0, 3)); o1 = 2'($urandom_range(0, 3));
      w = v == 2'b01 ? 1'b0 : v == 2'b10 ? 1'b1 : ~model_last;
      model_last = w;
      er = w ? 2'b10 : 2'b01;
      e = w ? ref_op(a1, b1, o1) : ref_op(a0, b0, o0);
      txn(v, a0, b0, o0, a1, b1, o1, $urandom_range(0, 3), rdy, vobs, lat, res, z, h, i, acc);
      total++; if (rdy !== er || vobs !== er || lat !== 1) begin
        bad++; $display("FAIL rnd_grant[%0d] got ready=%b valid=%b lat=%0d exp %b %b 1", k, rdy, vobs, lat, er, er);
      end
      total++; if (res !== e || z !== (e == '0)) begin
        bad++; $display("FAIL rnd_result[%0d] got=%h z=%b exp=%h z=%b", k, res, z, e, e == '0);
      end
      total++; if (h !== 1'b1 || i !== 1'b1) begin
        bad++; $display("FAIL rnd_handshake[%0d] got held_ok=%b idle_ok=%b exp 1 1", k, h, i);
      end
    end
  endtask

  task automatic test_settle();
    int lat;
    bus4.req_valid = 2'b01; bus4.req_a0 = '1; bus4.req_b0 = 64'hA5; bus4.req_op0 = OP_AND;
    #1;
    total++; if (bus4.req_ready !== 2'b01) begin bad++; $display("FAIL settle_ready got=%b exp=01", bus4.req_ready); end
    @(posedge clk); @(negedge clk);
    lat = 0;
    while (bus4.rsp_valid == 2'b00 && lat < 30) begin
      bus4.req_a0 = rnd64(); bus4.req_b0 = rnd64(); bus4.req_op0 = logic_op_e'($urandom_range(0, 3));
      bus4.req_valid = 2'($urandom_range(0, 3));
      @(posedge clk); @(negedge clk);
      lat++;
    end
    total++; if (lat !== 4 || bus4.rsp_valid !== 2'b01) begin
      bad++; $display("FAIL settle_latency got lat=%0d valid=%b exp 4 01", lat, bus4.rsp_valid);
    end
    total++; if (bus4.rsp_result !== 64'hA5 || bus4.rsp_zero !== 1'b0) begin
      bad++; $display("FAIL settle_result got=%h z=%b exp=a5 z=0", bus4.rsp_result, bus4.rsp_zero);
    end
    bus4.req_valid = 2'b00; bus4.rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    bus4.rsp_ready = 2'b00;
    total++; if (bus4.rsp_valid !== 2'b00 || bus4.busy !== 1'b0) begin
      bad++; $display("FAIL settle_done got valid=%b busy=%b exp 00 0", bus4.rsp_valid, bus4.busy);
    end
  endtask

  task automatic test_abort();
    int seen;
    bus4.req_valid = 2'b10; bus4.req_a1 = '1; bus4.req_b1 = 64'h1; bus4.req_op1 = OP_OR;
    @(posedge clk); @(negedge clk);
    bus4.req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b exp=1", bus4.busy); end
    bus4.req_valid = 2'b01;
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus4.busy !== 1'b0 || bus4.rsp_valid !== 2'b00 || bus4.req_ready !== 2'b00 || bus4.rsp_result !== '0 || bus4.rsp_zero !== 1'b0) begin
      bad++; $display("FAIL abort_async got busy=%b valid=%b ready=%b res=%h z=%b exp 0 00 00 0 0",
                      bus4.busy, bus4.rsp_valid, bus4.req_ready, bus4.rsp_result, bus4.rsp_zero);
    end
    bus4.req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (bus4.rsp_valid !== 2'b00 || bus4.busy !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_rsp got=%0d exp=0", seen); end
    model_last = 1'b1;
  endtask

  initial begin
    test_reset();
    test_xor();
    test_zero();
    test_alternation();
    test_hold();
    test_random();
    test_settle();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
